// File: rtl/legv8_pkg.sv
// Shared definitions for the LegV8 datapath: default widths and the
// index of the hardwired-zero register.
package legv8_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;

  // The zero register is always the top entry of the file.
  function automatic int ZERO_REG_IDX(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/reg_n.sv
// N-bit storage register with synchronous reset and load enable; one
// instance per register-file entry.
module reg_n #(
  parameter int N = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Per-register pending bits marking outstanding loads. A reservation in the
// same cycle as a write to that register wins, since it is the newer load.
module rf_scoreboard
  import legv8_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] RA,
  input  logic              write0,
  input  logic [ADDR_W-1:0] DA0,
  input  logic              write1,
  input  logic [ADDR_W-1:0] DA1,
  input  logic [ADDR_W-1:0] SA,
  input  logic [ADDR_W-1:0] SB,
  output logic              rawPendA,
  output logic              rawPendB
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG_IDX(ADDR_W));

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] setVec;
  logic [DEPTH-1:0] clrVec;

  always_comb begin
    setVec = '0;
    clrVec = '0;
    if (rsv)
      setVec[RA] = 1'b1;
    if (write0)
      clrVec[DA0] = 1'b1;
    if (write1)
      clrVec[DA1] = 1'b1;
    if (ZERO_REG)
      setVec[ZADDR] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset)
      pending <= '0;
    else
      pending <= setVec | (pending & ~clrVec);
  end

  assign rawPendA = pending[SA] & ~(ZERO_REG && (SA == ZADDR));
  assign rawPendB = pending[SB] & ~(ZERO_REG && (SB == ZADDR));

endmodule

// File: rtl/reg_file_sb.sv
// Two-write, two-read register file with optional write-to-read bypass,
// a load scoreboard, a hardwired-zero top entry and low-bit peripheral taps.
module reg_file_sb
  import legv8_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter bit ZERO_REG  = 1'b1,
  parameter bit BYPASS    = 1'b1,
  parameter int TAP_COUNT = 8,
  parameter int TAP_W     = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       write0,
  input  logic [ADDR_W-1:0]          DA0,
  input  logic [DATA_W-1:0]          D0,
  input  logic                       write1,
  input  logic [ADDR_W-1:0]          DA1,
  input  logic [DATA_W-1:0]          D1,
  input  logic [ADDR_W-1:0]          SA,
  input  logic [ADDR_W-1:0]          SB,
  output logic [DATA_W-1:0]          A,
  output logic [DATA_W-1:0]          B,
  input  logic                       rsv,
  input  logic [ADDR_W-1:0]          RA,
  output logic                       pendA,
  output logic                       pendB,
  output logic [TAP_COUNT*TAP_W-1:0] taps
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG_IDX(ADDR_W));

  logic [DATA_W-1:0] regs [DEPTH];

  // Port 1 (load writeback) takes the data when both ports hit one entry.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam bit IS_ZERO = ZERO_REG && (i == DEPTH - 1);
    logic              hit0;
    logic              hit1;
    logic              load;
    logic [DATA_W-1:0] d;

    assign hit0 = write0 && (DA0 == ADDR_W'(i));
    assign hit1 = write1 && (DA1 == ADDR_W'(i));
    assign load = (hit0 || hit1) && !IS_ZERO;
    assign d    = hit1 ? D1 : D0;

    reg_n #(.N(DATA_W)) u_reg (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .d     (d),
      .q     (regs[i])
    );
  end

  function automatic logic [DATA_W-1:0] readSel(input logic [ADDR_W-1:0] sel,
                                                input logic [DATA_W-1:0] stored);
    if (ZERO_REG && (sel == ZADDR))
      return '0;
    if (BYPASS && write1 && (DA1 == sel))
      return D1;
    if (BYPASS && write0 && (DA0 == sel))
      return D0;
    return stored;
  endfunction

  always_comb begin
    A = readSel(SA, regs[SA]);
    B = readSel(SB, regs[SB]);
  end

  logic rawPendA;
  logic rawPendB;

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clock    (clock),
    .reset    (reset),
    .rsv      (rsv),
    .RA       (RA),
    .write0   (write0),
    .DA0      (DA0),
    .write1   (write1),
    .DA1      (DA1),
    .SA       (SA),
    .SB       (SB),
    .rawPendA (rawPendA),
    .rawPendB (rawPendB)
  );

  // A write landing this cycle resolves the pending load unless a new one
  // is issued to the same register in the same cycle.
  logic wrHitA, wrHitB, rsvHitA, rsvHitB;

  assign wrHitA  = (write0 && (DA0 == SA)) || (write1 && (DA1 == SA));
  assign wrHitB  = (write0 && (DA0 == SB)) || (write1 && (DA1 == SB));
  assign rsvHitA = rsv && (RA == SA);
  assign rsvHitB = rsv && (RA == SB);

  assign pendA = rawPendA && !(BYPASS && wrHitA && !rsvHitA);
  assign pendB = rawPendB && !(BYPASS && wrHitB && !rsvHitB);

  for (genvar t = 0; t < TAP_COUNT; t++) begin : g_tap
    if (t < DEPTH) begin : g_live
      assign taps[t*TAP_W +: TAP_W] = regs[t][TAP_W-1:0];
    end else begin : g_none
      assign taps[t*TAP_W +: TAP_W] = '0;
    end
  end

  always @(posedge clock) begin
    assert (TAP_COUNT <= DEPTH && TAP_W <= DATA_W)
      else $error("reg_file_sb: TAP_COUNT/TAP_W exceed register file geometry");
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: a bypassing and a non-bypassing instance
// share stimulus and are checked against an array-based model.
module tb_reg_file_sb;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int TW = 8 * 16;
  localparam logic [AW-1:0] ZR = 5'd31;

  typedef struct {
    logic          rst;
    logic          w0;
    logic [AW-1:0] da0;
    logic [DW-1:0] d0;
    logic          w1;
    logic [AW-1:0] da1;
    logic [DW-1:0] d1;
    logic [AW-1:0] sa;
    logic [AW-1:0] sb;
    logic          rsv;
    logic [AW-1:0] ra;
  } stim_t;

  typedef struct {
    logic [DW-1:0] a, b, aNb, bNb;
    logic          pa, pb, paNb, pbNb;
    logic [TW-1:0] taps;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset, write0, write1, rsv;
  logic [AW-1:0] DA0, DA1, SA, SB, RA;
  logic [DW-1:0] D0, D1;
  logic [DW-1:0] A, B, aNb, bNb;
  logic          pendA, pendB, pendANb, pendBNb;
  logic [TW-1:0] taps, tapsNb;

  reg_file_sb dut (
    .clock(clock), .reset(reset), .write0(write0), .DA0(DA0), .D0(D0),
    .write1(write1), .DA1(DA1), .D1(D1), .SA(SA), .SB(SB), .A(A), .B(B),
    .rsv(rsv), .RA(RA), .pendA(pendA), .pendB(pendB), .taps(taps)
  );

  reg_file_sb #(.BYPASS(1'b0)) dutNb (
    .clock(clock), .reset(reset), .write0(write0), .DA0(DA0), .D0(D0),
    .write1(write1), .DA1(DA1), .D1(D1), .SA(SA), .SB(SB), .A(aNb), .B(bNb),
    .rsv(rsv), .RA(RA), .pendA(pendANb), .pendB(pendBNb), .taps(tapsNb)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [32];
  bit            pend [32];
  exp_t          expQ [$];
  int            checkCount = 0;
  int            passCount  = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, w0: 1'b0, da0: '0, d0: '0, w1: 1'b0, da1: '0, d1: '0,
          sa: '0, sb: '0, rsv: 1'b0, ra: '0};
    return s;
  endfunction

  function automatic logic [DW-1:0] expRead(logic [AW-1:0] a, stim_t s, bit byp);
    if (a == ZR) return '0;
    if (byp && s.w1 && s.da1 == a) return s.d1;
    if (byp && s.w0 && s.da0 == a) return s.d0;
    return mem[a];
  endfunction

  function automatic bit expPend(logic [AW-1:0] a, stim_t s, bit byp);
    bit written;
    if (a == ZR) return 1'b0;
    written = (s.w0 && s.da0 == a) || (s.w1 && s.da1 == a);
    if (byp && written && !(s.rsv && s.ra == a)) return 1'b0;
    return pend[a];
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clock);
    #1;
    reset = s.rst; write0 = s.w0; DA0 = s.da0; D0 = s.d0;
    write1 = s.w1; DA1 = s.da1; D1 = s.d1;
    SA = s.sa; SB = s.sb; rsv = s.rsv; RA = s.ra;
    e.a    = expRead(s.sa, s, 1'b1);
    e.b    = expRead(s.sb, s, 1'b1);
    e.aNb  = expRead(s.sa, s, 1'b0);
    e.bNb  = expRead(s.sb, s, 1'b0);
    e.pa   = expPend(s.sa, s, 1'b1);
    e.pb   = expPend(s.sb, s, 1'b1);
    e.paNb = expPend(s.sa, s, 1'b0);
    e.pbNb = expPend(s.sb, s, 1'b0);
    for (int i = 0; i < 8; i++) e.taps[i*16 +: 16] = mem[i][15:0];
    expQ.push_back(e);
    // State the model holds after the coming edge.
    if (s.rst) begin
      for (int i = 0; i < 32; i++) begin mem[i] = '0; pend[i] = 1'b0; end
    end else begin
      if (s.w0 && s.da0 != ZR) mem[s.da0] = s.d0;
      if (s.w1 && s.da1 != ZR) mem[s.da1] = s.d1;
      if (s.w0) pend[s.da0] = 1'b0;
      if (s.w1) pend[s.da1] = 1'b0;
      if (s.rsv && s.ra != ZR) pend[s.ra] = 1'b1;
    end
  endtask

  task automatic cmp(input string name, input logic [TW-1:0] act, input logic [TW-1:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("A", TW'(A), TW'(e.a));
    cmp("B", TW'(B), TW'(e.b));
    cmp("pendA", TW'(pendA), TW'(e.pa));
    cmp("pendB", TW'(pendB), TW'(e.pb));
    cmp("taps", taps, e.taps);
    cmp("A_nobyp", TW'(aNb), TW'(e.aNb));
    cmp("B_nobyp", TW'(bNb), TW'(e.bNb));
    cmp("pendA_nobyp", TW'(pendANb), TW'(e.paNb));
    cmp("pendB_nobyp", TW'(pendBNb), TW'(e.pbNb));
    cmp("taps_nobyp", tapsNb, e.taps);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  function automatic logic [AW-1:0] pickAddr();
    return ($urandom_range(0, 4) == 0) ? ZR : AW'($urandom_range(0, 11));
  endfunction

  initial begin
    stim_t s;
    stim_t dirQ [$];

    reset = 1'b1; write0 = 1'b0; write1 = 1'b0; rsv = 1'b0;
    DA0 = '0; DA1 = '0; D0 = '0; D1 = '0; SA = '0; SB = '0; RA = '0;
    for (int i = 0; i < 32; i++) begin mem[i] = '0; pend[i] = 1'b0; end
    repeat (2) @(posedge clock);

    s = idle(); s.w0 = 1; s.da0 = 3; s.d0 = 64'h1234; s.sa = 3;   dirQ.push_back(s);
    s = idle(); s.rst = 1; s.sa = 3; s.w1 = 1; s.da1 = 3; s.d1 = 64'h77; s.rsv = 1; s.ra = 3; dirQ.push_back(s);
    s = idle(); s.sa = 3; s.sb = 3;                                 dirQ.push_back(s);
    s = idle(); s.w0 = 1; s.da0 = ZR; s.d0 = 64'hFFFF; s.sa = ZR;   dirQ.push_back(s);
    s = idle(); s.sa = ZR;                                          dirQ.push_back(s);
    s = idle(); s.w0 = 1; s.da0 = 5; s.d0 = 64'hAAAA;
    s.w1 = 1; s.da1 = 5; s.d1 = 64'hBBBB; s.sa = 5;                 dirQ.push_back(s);
    s = idle(); s.sa = 5; s.w0 = 1; s.da0 = 7; s.d0 = 64'h1111;     dirQ.push_back(s);
    s = idle(); s.w0 = 1; s.da0 = 7; s.d0 = 64'h55; s.sa = 7;       dirQ.push_back(s);
    s = idle(); s.sa = 7; s.rsv = 1; s.ra = 9;                      dirQ.push_back(s);
    s = idle(); s.sb = 9;                                           dirQ.push_back(s);
    s = idle(); s.w1 = 1; s.da1 = 9; s.d1 = 64'h42; s.sb = 9;       dirQ.push_back(s);
    s = idle(); s.sb = 9;                                           dirQ.push_back(s);
    s = idle(); s.rsv = 1; s.ra = 4; s.w0 = 1; s.da0 = 4; s.d0 = 64'h10; s.sa = 4; dirQ.push_back(s);
    s = idle(); s.sa = 4;                                           dirQ.push_back(s);
    s = idle(); s.rsv = 1; s.ra = ZR; s.sa = ZR;                    dirQ.push_back(s);
    s = idle(); s.sa = ZR; s.sb = 4;                                dirQ.push_back(s);

    foreach (dirQ[i]) applyStimulus(dirQ[i]);

    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.rst = ($urandom_range(0, 49) == 0);
      s.w0  = $urandom_range(0, 1);
      s.da0 = pickAddr();
      s.d0  = {$urandom, $urandom};
      s.w1  = ($urandom_range(0, 2) == 0);
      s.da1 = pickAddr();
      s.d1  = {$urandom, $urandom};
      s.rsv = ($urandom_range(0, 2) == 0);
      s.ra  = pickAddr();
      s.sa  = pickAddr();
      s.sb  = pickAddr();
      applyStimulus(s);
    end

    repeat (3) @(posedge clock);
    #1;
    checkCount++;
    if (expQ.size() == 0) passCount++;
    else $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
